// File: rtl/alu_share_arb_if.sv
// Requester-side request/response bundle for the shared ALU arbiter.
interface alu_share_arb_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*64-1:0] req_a;
  logic [NUM_REQ*64-1:0] req_b;
  logic [NUM_REQ*3-1:0]  req_op;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [NUM_REQ-1:0]    rsp_ready;
  logic [63:0]           rsp_result;
  logic                  rsp_zero;
  logic                  rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin arbiter/sequencer time-sharing one external 64-bit ALU among
// NUM_REQ requesters: accept, execute for one cycle, then hold the response.
module alu_share_arb #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic           clk,
  input  logic           rst,
  alu_share_arb_if.slave bus,
  output logic [63:0]    alu_a,
  output logic [63:0]    alu_b,
  output logic [2:0]     alu_op,
  input  logic [63:0]    alu_result,
  input  logic           alu_zero
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t             state_r, state_s;
  logic [IDX_W-1:0]   ptr_r, grant_r, win_idx_s, ptr_next_s;
  logic               win_found_s;
  logic               rsp_hs_s;
  logic [NUM_REQ-1:0] req_ready_s, rsp_valid_r;
  logic [63:0]        sel_a_s, sel_b_s, alu_a_r, alu_b_r, rsp_result_r;
  logic [2:0]         sel_op_s, alu_op_r;
  logic               rsp_zero_r, rsp_err_r;

  // Round-robin scan starting at ptr_r for the first valid requester.
  always_comb begin
    int idx_v;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    idx_v       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_v = (int'(ptr_r) + k) % NUM_REQ;
      if (!win_found_s && bus.req_valid[IDX_W'(idx_v)]) begin
        win_found_s = 1'b1;
        win_idx_s   = IDX_W'(idx_v);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Operand mux selecting the winner's request fields.
  always_comb begin
    sel_a_s  = 64'd0;
    sel_b_s  = 64'd0;
    sel_op_s = 3'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx_s == IDX_W'(i)) begin
        sel_a_s  = bus.req_a[64*i +: 64];
        sel_b_s  = bus.req_b[64*i +: 64];
        sel_op_s = bus.req_op[3*i +: 3];
      end else begin
        sel_a_s  = sel_a_s;
      end
    end
  end

  // Next-state logic and the combinational request grant (IDLE only).
  always_comb begin
    state_s     = state_r;
    req_ready_s = '0;
    rsp_hs_s    = |(rsp_valid_r & bus.rsp_ready);
    ptr_next_s  = (grant_r == IDX_W'(NUM_REQ - 1)) ? '0 : grant_r + IDX_W'(1);
    case (state_r)
      IDLE: begin
        if (win_found_s) begin
          req_ready_s = NUM_REQ'(1) << win_idx_s;
          state_s     = EXEC;
        end else begin
          state_s     = IDLE;
        end
      end
      EXEC: state_s = RESP;
      RESP: begin
        if (rsp_hs_s) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath: latch operands on accept, capture ALU outputs, release on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r        <= '0;
      grant_r      <= '0;
      alu_a_r      <= 64'd0;
      alu_b_r      <= 64'd0;
      alu_op_r     <= 3'd0;
      rsp_result_r <= 64'd0;
      rsp_zero_r   <= 1'b0;
      rsp_err_r    <= 1'b0;
      rsp_valid_r  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (win_found_s) begin
            alu_a_r  <= sel_a_s;
            alu_b_r  <= sel_b_s;
            alu_op_r <= sel_op_s;
            grant_r  <= win_idx_s;
          end
        end
        EXEC: begin
          rsp_result_r <= alu_result;
          rsp_zero_r   <= alu_zero;
          rsp_err_r    <= (alu_op_r == 3'b111);
          rsp_valid_r  <= NUM_REQ'(1) << grant_r;
        end
        RESP: begin
          if (rsp_hs_s) begin
            rsp_valid_r <= '0;
            ptr_r       <= ptr_next_s;
          end
        end
        default: rsp_valid_r <= '0;
      endcase
    end
  end

  assign alu_a          = alu_a_r;
  assign alu_b          = alu_b_r;
  assign alu_op         = alu_op_r;
  assign bus.req_ready  = req_ready_s;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_result = rsp_result_r;
  assign bus.rsp_zero   = rsp_zero_r;
  assign bus.rsp_err    = rsp_err_r;
endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
Round-robin arbiter and sequencer that shares one alu64 instance among NUM_REQ requesters. It accepts one operation at a time through per-requester valid/ready request channels and latches the operands. It drives the external ALU from registers, captures result and zero flag, and returns them on a shared response bus with a per-requester valid/ready handshake. It sits between issue/AGU-style clients and the single ALU datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
IDX_W, $clog2(NUM_REQ), grant index width (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  NUM_REQ  request valid per requester
req_ready  output  NUM_REQ  request accepted, one-hot or zero
req_a  input  NUM_REQ*64  operand A, requester i at [64*i +: 64]
req_b  input  NUM_REQ*64  operand B, same packing
req_op  input  NUM_REQ*3  ALU op code, requester i at [3*i +: 3]
alu_a  output  64  to ALU operand A
alu_b  output  64  to ALU operand B
alu_op  output  3  to ALU op select
alu_result  input  64  from ALU result
alu_zero  input  1  from ALU zero flag
rsp_valid  output  NUM_REQ  response valid, one-hot or zero
rsp_ready  input  NUM_REQ  response consumed per requester
rsp_result  output  64  shared response data
rsp_zero  output  1  captured zero flag
rsp_err  output  1  1 if latched op was 3'b111 (unsupported)

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All state updates on the rising edge of clk.
- FSM states: IDLE, EXEC, RESP.
- Reset: state=IDLE; priority pointer ptr=0; alu_a/alu_b=0; alu_op=0; rsp_result=0; rsp_zero=0; rsp_err=0; rsp_valid=0; req_ready=0.
- IDLE, arbitration:
  - The winner is the first i with req_valid[i]=1, scanning ptr, ptr+1, … modulo NUM_REQ.
  - req_ready[winner]=1 combinationally, in IDLE only. All other req_ready bits are 0.
  - On that edge, latch req_a/req_b/req_op[winner] into alu_a/alu_b/alu_op, store the grant index g, and go to EXEC.
  - If no request is valid, stay in IDLE with req_ready=0.
- EXEC, one cycle:
  - alu_a/alu_b/alu_op remain stable, driven from registers.
  - At the end of the cycle, capture rsp_result<=alu_result and rsp_zero<=alu_zero.
  - Set rsp_err<=(alu_op==3'b111). The ALU already returns 0 for that op, so rsp_zero=1.
  - Next state is RESP.
- RESP:
  - rsp_valid[g]=1 (registered); all other bits are 0.
  - rsp_result, rsp_zero and rsp_err hold until the handshake completes.
  - On rsp_valid[g]&rsp_ready[g]: clear rsp_valid, set ptr<=(g+1) mod NUM_REQ, go to IDLE.
  - rsp_ready bits other than g are ignored.
- Latency: request accept edge to rsp_valid is 2 cycles. Minimum issue interval is 3 cycles per operation when rsp_ready is held high.
- Operand registers keep their last value outside EXEC and are not cleared between operations.
- req_valid may drop without acceptance. No state changes unless a handshake occurs.
- Requester i may assert req_valid while its own response is pending. It is not granted until the FSM returns to IDLE.
- Fairness: the pointer advances past the served requester. With N continuous requesters, each is served once every N operations.
- rst asserted in any state aborts the in-flight operation: no response is issued, and state/ptr return to reset values on that edge.
- Simultaneous rsp handshake and new req_valid: the new request is arbitrated in the following IDLE cycle, using the updated ptr.

Test Plan:
- Reset then single request: req_valid[2]=1, a=5, b=3, op=000 -> req_ready[2] pulses 1 cycle; 2 cycles later rsp_valid[2]=1, rsp_result=8, rsp_zero=0, rsp_err=0.
- Zero and error paths:
  - SUB with a=b=0x1234 -> rsp_result=0, rsp_zero=1.
  - op=111 -> rsp_result=0, rsp_zero=1, rsp_err=1.
- Round-robin, all four requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; one response every 3 cycles.
- Backpressure: rsp_ready[1]=0 for 5 cycles while req 0 and 3 are valid -> rsp_valid[1] and rsp_result remain stable; no req_ready asserted; after rsp_ready[1]=1, the next grant is 3.
- Reset mid-operation: assert rst in EXEC -> next cycle state=IDLE, rsp_valid=0, ptr=0; the aborted requester gets no response and is granted first when it re-requests.
- Shift ops: SLL a=1, b=63 -> 0x8000000000000000; SRL a=0x8000000000000000, b=64 -> the ALU uses b[5:0]=0, so rsp_result=0x8000000000000000.
